// File: rtl/video_timing_gen.sv
// Raster timing generator: per-axis phase FSMs with down-counters, registered x/y/de/sync/strobes.
// Optional VIDEO_TIMING_PREFETCH_EN adds fetch_de, de advanced by PREFETCH clock-enabled cycles.
//
// state  | meaning
// H_ACT  | visible pixels of a line
// H_FP   | horizontal front porch
// H_SYNC | hsync asserted
// H_BP   | horizontal back porch; last pixel wraps x to 0
// V_ACT  | visible lines of a frame
// V_FP   | vertical front porch
// V_SYNC | vsync asserted (whole lines)
// V_BP   | vertical back porch; last line wraps y to 0
module video_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1,
  parameter int PREFETCH  = 2
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        ce,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VIDEO_TIMING_PREFETCH_EN
  ,
  output logic        fetch_de
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_LEN = 12'(H_VISIBLE - 1);
  localparam logic [11:0] H_FP_LEN  = 12'(H_FRONT - 1);
  localparam logic [11:0] H_SY_LEN  = 12'(H_SYNC - 1);
  localparam logic [11:0] H_BP_LEN  = 12'(H_BACK - 1);
  localparam logic [11:0] V_ACT_LEN = 12'(V_VISIBLE - 1);
  localparam logic [11:0] V_FP_LEN  = 12'(V_FRONT - 1);
  localparam logic [11:0] V_SY_LEN  = 12'(V_SYNC - 1);
  localparam logic [11:0] V_BP_LEN  = 12'(V_BACK - 1);
  localparam logic        HS_ON     = (H_POL != 0);
  localparam logic        VS_ON     = (V_POL != 0);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_POL < 0 || H_POL > 1 || V_POL < 0 || V_POL > 1 || PREFETCH < 1 ||
      H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_param
    $error("video_timing_gen: illegal timing parameters");
  end

`ifdef VIDEO_TIMING_PREFETCH_EN
  if (PREFETCH > H_BACK) begin : g_bad_prefetch
    $error("video_timing_gen: PREFETCH must not exceed H_BACK");
  end
`endif

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap;
  logic        v_wrap;

  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    x_d       = x_q;
    h_wrap    = 1'b0;
    if (ce) begin
      x_d = x_q + 12'd1;
      if (h_cnt_q == 12'd0) begin
        case (h_state_q)
          H_ACT: begin h_state_d = H_FP; h_cnt_d = H_FP_LEN; end
          H_FP:  begin h_state_d = H_SY; h_cnt_d = H_SY_LEN; end
          H_SY:  begin h_state_d = H_BP; h_cnt_d = H_BP_LEN; end
          default: begin
            h_state_d = H_ACT;
            h_cnt_d   = H_ACT_LEN;
            x_d       = 12'd0;
            h_wrap    = 1'b1;
          end
        endcase
      end else begin
        h_cnt_d = h_cnt_q - 12'd1;
      end
    end
  end

  // The vertical axis only moves on the pixel where x wraps.
  always_comb begin
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    y_d       = y_q;
    v_wrap    = 1'b0;
    if (h_wrap) begin
      y_d = y_q + 12'd1;
      if (v_cnt_q == 12'd0) begin
        case (v_state_q)
          V_ACT: begin v_state_d = V_FP; v_cnt_d = V_FP_LEN; end
          V_FP:  begin v_state_d = V_SY; v_cnt_d = V_SY_LEN; end
          V_SY:  begin v_state_d = V_BP; v_cnt_d = V_BP_LEN; end
          default: begin
            v_state_d = V_ACT;
            v_cnt_d   = V_ACT_LEN;
            y_d       = 12'd0;
            v_wrap    = 1'b1;
          end
        endcase
      end else begin
        v_cnt_d = v_cnt_q - 12'd1;
      end
    end
  end

  always_comb begin
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      de_d          = (h_state_d == H_ACT) && (v_state_d == V_ACT);
      hsync_d       = (h_state_d == H_SY) ? HS_ON : ~HS_ON;
      vsync_d       = (v_state_d == V_SY) ? VS_ON : ~VS_ON;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

`ifdef VIDEO_TIMING_PREFETCH_EN
  localparam logic [12:0] H_TOTAL_W = 13'(H_TOTAL);
  localparam logic [12:0] PF_W      = 13'(PREFETCH);

  logic        fetch_de_q, fetch_de_d;
  logic [12:0] fx;
  logic [11:0] fy;

  // Look PREFETCH pixels ahead of the next pixel; past the line end that lands on the next line.
  always_comb begin
    fetch_de_d = fetch_de_q;
    fx         = {1'b0, x_d} + PF_W;
    fy         = y_d;
    if (fx >= H_TOTAL_W) begin
      fx = fx - H_TOTAL_W;
      fy = (y_d == V_LAST) ? 12'd0 : y_d + 12'd1;
    end
    if (ce) begin
      fetch_de_d = (fx < 13'(H_VISIBLE)) && (fy < 12'(V_VISIBLE));
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      fetch_de_q <= 1'b0;
    end else begin
      fetch_de_q <= fetch_de_d;
    end
  end

  assign fetch_de = fetch_de_q;
`endif

  // Reset parks both axes on the final blanking pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge pixclk) begin
    if (reset) begin
      h_state_q     <= H_BP;
      v_state_q     <= V_BP;
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
